// File: rtl/wb_ram_sync_if.sv
// Wishbone-style memory bus between a master and wb_ram_sync.
//   cyc, stb, we, addr, width, data_write : master -> slave request
//   data_read, ack, err, busy             : slave -> master response/status
interface wb_ram_sync_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic [31:0]       data_write;
  logic [31:0]       data_read;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output cyc, stb, we, addr, width, data_write,
    input  data_read, ack, err, busy
  );

  modport slave (
    input  cyc, stb, we, addr, width, data_write,
    output data_read, ack, err, busy
  );
endinterface

// File: rtl/wb_ram_sync.sv
// Wishbone-slave on-chip RAM built from four byte-lane banks (block RAM
// friendly), with registered reads, ack/err completion and an optional
// zero-clear sweep after reset.
//   iClk : system clock, rising edge
//   iRst : asynchronous active-low reset
//   bus  : slave side of wb_ram_sync_if (cyc/stb/we/addr/width/data_write in,
//          data_read/ack/err/busy out)
module wb_ram_sync #(
  parameter int unsigned SIZE         = 4096,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned CLEAR_ON_RST = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic         iClk,
  input  logic         iRst,
  wb_ram_sync_if.slave bus
);

  localparam int unsigned WORDS = SIZE / 4;
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned WW    = AW - 2;

  typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [WW-1:0] ptr;
  logic [1:0]    off_q;
  logic [1:0]    width_q;
  logic          we_q;
  logic          err_q;

  logic          accept;
  logic          bad;
  logic [1:0]    off;
  logic [WW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          mem_wr;
  logic          rd_en;
  logic [31:0]   rd_word;
  logic [31:0]   rd2_q;
  logic [31:0]   rd_sel;
  logic [31:0]   rd_aligned;
  logic          resp;

  assign off    = bus.addr[1:0];
  assign widx   = bus.addr[AW-1:2];
  assign accept = (state == IDLE) && bus.cyc && bus.stb;

  always_comb begin
    bad = (bus.addr >= ADDR_W'(SIZE));
    if (bus.width == 2'b01 && bus.addr[0]) bad = 1'b1;
    if (bus.width[1] && off != 2'b00)      bad = 1'b1;
  end

  always_comb begin
    case (bus.width)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  // Shifting the LSB-aligned write data up by the byte offset puts byte k
  // of the access onto lane off+k.
  assign wdata  = bus.data_write << {off, 3'b000};
  assign mem_wr = accept && bus.we && !bad;
  assign rd_en  = accept && !bus.we && !bad;

  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] bank [WORDS];
    logic [7:0] rd_lane;

    always_ff @(posedge iClk) begin
      if (state == CLEAR) begin
        bank[ptr] <= '0;
      end else if (mem_wr && be[n]) begin
        bank[widx] <= wdata[8*n +: 8];
      end
      if (rd_en) begin
        rd_lane <= bank[widx];
      end
    end

    assign rd_word[8*n +: 8] = rd_lane;
  end

  // Second read stage, only observed when READ_LAT is 2.
  always_ff @(posedge iClk) begin
    if (state == RD_WAIT) begin
      rd2_q <= rd_word;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state   <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
      ptr     <= '0;
      off_q   <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) begin
        ptr <= ptr + WW'(1);
      end
      if (accept) begin
        off_q   <= off;
        width_q <= bus.width;
        we_q    <= bus.we;
        err_q   <= bad;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR: begin
        if (ptr == WW'(WORDS - 1)) state_nx = IDLE;
      end
      IDLE: begin
        if (bus.cyc && bus.stb) begin
          state_nx = (bad || bus.we || READ_LAT < 2) ? RESP : RD_WAIT;
        end
      end
      RD_WAIT: state_nx = bus.cyc ? RESP : IDLE;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gating the response with cyc makes a master abort in RESP silent.
  always_comb begin
    rd_sel     = (READ_LAT >= 2) ? rd2_q : rd_word;
    rd_aligned = rd_sel >> {off_q, 3'b000};
    case (width_q)
      2'b00:   rd_aligned = rd_aligned & 32'h0000_00FF;
      2'b01:   rd_aligned = rd_aligned & 32'h0000_FFFF;
      default: ;
    endcase
  end

  assign resp          = (state == RESP) && bus.cyc;
  assign bus.ack       = resp && !err_q;
  assign bus.err       = resp && err_q;
  assign bus.busy      = (state == CLEAR);
  assign bus.data_read = (bus.ack && !we_q) ? rd_aligned : '0;

endmodule
